// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults, stage-count helper and the per-stage register record.
// The op field is present only when ADDER_PIPE_SUB_EN is defined.
package adder_pkg;

  localparam int unsigned WIDTH_DEF   = 6;
  localparam int unsigned STAGE_W_DEF = 2;
  // Upper bound on WIDTH; stage records are sized for it and the spare bits stay zero.
  localparam int unsigned MAX_W       = 64;

  function automatic int unsigned nstages(input int unsigned width, input int unsigned stage_w);
    return (width + stage_w - 1) / stage_w;
  endfunction

  typedef struct packed {
    logic             valid;
    logic [MAX_W:0]   sum;
    logic             carry;
    logic [MAX_W-1:0] rem_x;
    logic [MAX_W-1:0] rem_y;
`ifdef ADDER_PIPE_SUB_EN
    logic             op;
`endif
  } stage_t;

endpackage

// File: rtl/adder_pipe_stage.sv
// adder_pipe_stage: one SW-bit slice of the carry chain with its stage register and
// load/advance control. Honours ADDER_PIPE_SUB_EN through the op field of stage_t.
module adder_pipe_stage
  import adder_pkg::*;
#(
  parameter int unsigned POS   = 0,
  parameter int unsigned SW    = 2,
  parameter bit          LAST  = 1'b0,
  parameter int unsigned WIDTH = 6
) (
  input  logic   clk,
  input  logic   rst,
  input  stage_t up,
  input  logic   down_ready,
  output logic   ready,
  output stage_t q
);

  stage_t        stage_q;
  stage_t        stage_d;
  logic          op;
  logic [SW-1:0] a;
  logic [SW-1:0] b;
  logic [SW:0]   res;

  always_comb begin
`ifdef ADDER_PIPE_SUB_EN
    op = up.op;
`else
    op = 1'b0;
`endif
    a     = up.rem_x[SW-1:0];
    b     = op ? ~up.rem_y[SW-1:0] : up.rem_y[SW-1:0];
    res   = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, up.carry};
    ready = !stage_q.valid || down_ready;

    stage_d = stage_q;
    if (ready) begin
      stage_d.valid = up.valid;
      if (up.valid) begin
        stage_d                = up;
        stage_d.sum[POS +: SW] = res[SW-1:0];
        stage_d.carry          = res[SW];
        stage_d.rem_x          = up.rem_x >> SW;
        stage_d.rem_y          = up.rem_y >> SW;
        // Zero-extended ~y puts a 1 at bit WIDTH, so for subtraction the top bit is the inverted carry.
        if (LAST) stage_d.sum[WIDTH] = res[SW] ^ op;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign q = stage_q;

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: valid/ready pipelined unsigned adder, NSTAGES = ceil(WIDTH/STAGE_W) slices.
// Define ADDER_PIPE_SUB_EN to add the sub port (x - y as a WIDTH+1-bit two's-complement result).
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned STAGE_W = STAGE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s
);

  localparam int unsigned NSTAGES = nstages(WIDTH, STAGE_W);

  stage_t           head;
  stage_t           st_q [NSTAGES];
  logic [NSTAGES:0] rdy;
  logic             unused_tail;

  always_comb begin
    head                   = '0;
    head.valid             = in_valid;
    head.rem_x[WIDTH-1:0]  = x;
    head.rem_y[WIDTH-1:0]  = y;
`ifdef ADDER_PIPE_SUB_EN
    head.op                = sub;
    head.carry             = sub;
`endif
  end

  assign rdy[NSTAGES] = out_ready;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam bit          IS_LAST = (k == NSTAGES - 1);
    localparam int unsigned SLICE_W = IS_LAST ? WIDTH - k * STAGE_W : STAGE_W;
    stage_t up;

    if (k == 0) begin : g_head
      assign up = head;
    end else begin : g_link
      assign up = st_q[k-1];
    end

    adder_pipe_stage #(
      .POS  (k * STAGE_W),
      .SW   (SLICE_W),
      .LAST (IS_LAST),
      .WIDTH(WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .up        (up),
      .down_ready(rdy[k+1]),
      .ready     (rdy[k]),
      .q         (st_q[k])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = st_q[NSTAGES-1].valid;
  assign s         = st_q[NSTAGES-1].sum[WIDTH:0];
  // Operand and carry fields of the last stage have no consumer.
  assign unused_tail = ^st_q[NSTAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: table vectors, exhaustive sweep, back-pressure and reset sequences
// for adder_pipe at 6/2, plus directed checks of the 7/3 and single-stage builds.
module tb_adder_pipe;

  localparam int unsigned W  = 6;
  localparam int unsigned W1 = 7;
  localparam int unsigned N  = 3;
  localparam int unsigned N7 = 3;
  localparam int unsigned N1 = 1;
`ifdef ADDER_PIPE_SUB_EN
  localparam int unsigned NV = 14;
`else
  localparam int unsigned NV = 6;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;
`ifdef ADDER_PIPE_SUB_EN
  logic          sub = 1'b0;
`endif
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    s;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [6:0] b_x = '0;
  logic [6:0] b_y = '0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic [7:0] b_s;

  logic       c_in_valid = 1'b0;
  logic       c_in_ready;
  logic [5:0] c_x = '0;
  logic [5:0] c_y = '0;
  logic       c_out_valid;
  logic       c_out_ready = 1'b1;
  logic [6:0] c_s;

  typedef struct {
    logic [W:0]  exp;
    int unsigned acc;
  } sb_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W:0]   e;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs [NV];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  bit          chk_lat = 1'b0;
  bit          stalled = 1'b0;
  logic [W:0]  last_s = '0;

  adder_pipe #(.WIDTH(6), .STAGE_W(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
`ifdef ADDER_PIPE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s)
  );

  adder_pipe #(.WIDTH(7), .STAGE_W(3)) u_dut7 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x), .y(b_y),
`ifdef ADDER_PIPE_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(b_out_valid), .out_ready(b_out_ready), .s(b_s)
  );

  adder_pipe #(.WIDTH(6), .STAGE_W(6)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .x(c_x), .y(c_y),
`ifdef ADDER_PIPE_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(c_out_valid), .out_ready(c_out_ready), .s(c_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard consumer: samples before each edge whether a result leaves on it.
  always begin
    sb_t e;
    @(negedge clk);
    #3;
    if (!rst) begin
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_s", s, last_s);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got s=%0d, expected no result", s);
        end else begin
          e = sb_q.pop_front();
          chk("sum", s, e.exp);
          if (chk_lat) chk("latency", cyc - e.acc, N);
        end
      end
      stalled = out_valid && !out_ready;
      last_s  = s;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                      input logic [W:0] e);
    int unsigned w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    x = a;
    y = b;
`ifdef ADDER_PIPE_SUB_EN
    sub = op;
`else
    if (op) $display("note: subtract vector skipped in add-only build");
`endif
    #3;
    while (!in_ready && w < 100) begin
      w++;
      @(negedge clk);
      #3;
    end
    if (chk_lat) chk("accept_wait", w, 0);
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0d, expected 1", in_ready);
    end else begin
      sb_q.push_back('{exp: e, acc: cyc});
    end
  endtask

  task automatic drain();
    int unsigned w = 0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  task automatic one_b(input logic [6:0] a, input logic [6:0] b, input logic [7:0] e);
    int unsigned lat = 0;
    @(negedge clk);
    b_in_valid = 1'b1;
    b_x = a;
    b_y = b;
    #3;
    chk("b_in_ready", b_in_ready, 1);
    @(negedge clk);
    b_in_valid = 1'b0;
    #3;
    while (!b_out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
      #3;
    end
    chk("b_latency", lat, N7 - 1);
    chk("b_sum", b_s, e);
  endtask

  task automatic one_c(input logic [5:0] a, input logic [5:0] b, input logic [6:0] e);
    int unsigned lat = 0;
    @(negedge clk);
    c_in_valid = 1'b1;
    c_x = a;
    c_y = b;
    #3;
    chk("c_in_ready", c_in_ready, 1);
    @(negedge clk);
    c_in_valid = 1'b0;
    #3;
    while (!c_out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
      #3;
    end
    chk("c_latency", lat, N1 - 1);
    chk("c_sum", c_s, e);
  endtask

  initial begin
    int unsigned acc;

    vecs[0] = '{6'd0,  6'd0,  1'b0, 7'd0};
    vecs[1] = '{6'd63, 6'd63, 1'b0, 7'd126};
    vecs[2] = '{6'd63, 6'd1,  1'b0, 7'd64};
    vecs[3] = '{6'd32, 6'd31, 1'b0, 7'd63};
    vecs[4] = '{6'd1,  6'd0,  1'b0, 7'd1};
    vecs[5] = '{6'd42, 6'd21, 1'b0, 7'd63};
`ifdef ADDER_PIPE_SUB_EN
    vecs[6]  = '{6'd5,  6'd9,  1'b1, 7'b1111100};
    vecs[7]  = '{6'd63, 6'd0,  1'b1, 7'd63};
    vecs[8]  = '{6'd0,  6'd63, 1'b1, 7'b1000001};
    vecs[9]  = '{6'd10, 6'd3,  1'b1, 7'd7};
    vecs[10] = '{6'd10, 6'd3,  1'b0, 7'd13};
    vecs[11] = '{6'd3,  6'd10, 1'b1, 7'b1111001};
    vecs[12] = '{6'd0,  6'd0,  1'b1, 7'd0};
    vecs[13] = '{6'd63, 6'd63, 1'b0, 7'd126};
`endif

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_s", s, 0);
    chk("reset_in_ready", in_ready, 1);

    // Table vectors, back-to-back.
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < int'(NV); i++) send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e);
    drain();

    // Exhaustive sweep at full throughput.
    chk_lat = 1'b1;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        send(W'(i), W'(j), 1'b0, W1'(i + j));
    drain();
    chk_lat = 1'b0;

    // Back-pressure: five offer cycles against a stalled consumer.
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x = W'(10 + acc);
      y = W'(acc);
      #3;
      if (in_ready) begin
        sb_q.push_back('{exp: W1'(10 + 2 * acc), acc: cyc});
        acc++;
      end
    end
    chk("bp_accepted", acc, 3);
    chk("bp_full_ready", in_ready, 0);
    @(negedge clk);
    out_ready = 1'b1;
    #3;
    chk("bp_passthru_ready", in_ready, 1);
    chk("bp_out_valid", out_valid, 1);
    if (in_ready) begin
      sb_q.push_back('{exp: W1'(10 + 2 * acc), acc: cyc});
      acc++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #3;
    chk("bp_refull_ready", in_ready, 0);
    chk("bp_queue_depth", sb_q.size(), 3);
    drain();

    // Reset with three operations in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(6'd1, 6'd2, 1'b0, 7'd3);
    send(6'd4, 6'd5, 1'b0, 7'd9);
    send(6'd6, 6'd7, 1'b0, 7'd13);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #3;
      chk("post_rst_out_valid", out_valid, 0);
    end

    // Non-divisible width 7/3.
    one_b(7'd127, 7'd1,   8'd128);
    one_b(7'd127, 7'd127, 8'd254);
    one_b(7'd100, 7'd27,  8'd127);

    // Single stage.
    one_c(6'd32, 6'd32, 7'd64);
    one_c(6'd63, 6'd63, 7'd126);
    @(negedge clk);
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_x = 6'd5;
    c_y = 6'd7;
    #3;
    chk("c_bp_accept", c_in_ready, 1);
    @(negedge clk);
    c_x = 6'd1;
    c_y = 6'd1;
    #3;
    chk("c_bp_full", c_in_ready, 0);
    chk("c_bp_valid", c_out_valid, 1);
    chk("c_bp_s", c_s, 12);
    @(negedge clk);
    #3;
    chk("c_bp_hold_s", c_s, 12);
    chk("c_bp_still_full", c_in_ready, 0);
    @(negedge clk);
    c_out_ready = 1'b1;
    #3;
    chk("c_bp_passthru", c_in_ready, 1);
    @(negedge clk);
    c_in_valid = 1'b0;
    #3;
    chk("c_bp_next_valid", c_out_valid, 1);
    chk("c_bp_next_s", c_s, 2);
    @(negedge clk);
    #3;
    chk("c_bp_empty", c_out_valid, 0);

    chk("final_queue_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined unsigned adder for WIDTH-bit operands with a WIDTH+1-bit result. The carry ripples through registered slices of STAGE_W bits. Valid/ready handshakes on input and output allow back-pressure at full throughput of one operation per cycle. It succeeds the fixed 6-bit combinational adder and is used wherever operand width or clock rate rules out a single-cycle carry chain.

## Interface
- WIDTH, 6: operand width in bits, ≥1
- STAGE_W, 2: bits added per pipeline stage, 1..WIDTH; NSTAGES = ceil(WIDTH/STAGE_W)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts operands this cycle
- x  in  WIDTH  operand A, unsigned
- y  in  WIDTH  operand B, unsigned
- sub  in  1  present only with ADDER_PIPE_SUB_EN; 1 = x − y
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- s  out  WIDTH+1  result

## Operation
- Input accepted on a rising edge with in_valid && in_ready; result delivered on a rising edge with out_valid && out_ready.
- Stage k (0..NSTAGES−1) computes bits [k·STAGE_W +: STAGE_W] of the sum plus the carry-in from stage k−1. Stage 0 carry-in = 0 (add) or 1 (sub).
- Each stage registers: valid bit, the result bits produced so far, the carry-out, and the not-yet-consumed upper operand bits.
- Last stage is narrower when WIDTH % STAGE_W ≠ 0. Its carry-out becomes s[WIDTH].
- s = x + y, exact, range 0..2^(WIDTH+1)−2; no overflow possible.
- Stage advance rule: stage k loads when its register is empty or it advances downstream. Last stage advances on out_ready. in_ready = !v[0] || advance[0].
- Bubbles collapse: an empty stage accepts data even while downstream is stalled.
- Results leave in acceptance order. There is no reordering and no drop.
- s holds stable while out_valid && !out_ready. Inputs are sampled only on acceptance.

## Timing
- Reset (async assert): all stage valid bits = 0, out_valid = 0, s = 0, in_ready = 1 on the first cycle after release. Deassertion is synchronous to clk.
- Latency: an operand accepted at edge t gives out_valid = 1 after edge t+NSTAGES−1, i.e. the result is visible NSTAGES−1 cycles after acceptance and consumable at edge t+NSTAGES. With NSTAGES = 1, a result accepted at edge t is visible right after that edge.
- Throughput: 1 result per cycle while out_ready = 1.
- Full: all NSTAGES stages valid and out_ready = 0 gives in_ready = 0. With out_ready = 1 in that state, in_ready = 1 in the same cycle (pass-through, no bubble).
- Simultaneous accept and deliver in one cycle is legal at every occupancy.
- Reset mid-operation discards every in-flight operation. No partial result is emitted.
- in_ready depends combinationally on out_ready. out_valid and s are purely registered.

## Configuration
- ADDER_PIPE_SUB_EN defined:
  - sub port exists and is sampled with x/y and carried with the operation.
  - sub = 1: stage 0 sees ~y with carry-in 1, zero-extended to WIDTH+1 bits (i.e. x + ~{1'b0,y} + 1).
  - Result is x − y as a (WIDTH+1)-bit two's-complement value, range −(2^WIDTH−1)..2^WIDTH−1.
- ADDER_PIPE_SUB_EN undefined: no sub port, no sub state registers, add only.

## Structure
- adder_pkg holds:
  - function nstages(WIDTH, STAGE_W)
  - the stage-register struct typedef (valid, partial sum, carry, remaining operands, op)
  - localparam defaults
- One sub-module, adder_pipe_stage, per slice. It contains the slice adder, stage registers and the load/advance logic. adder_pipe generate-instantiates NSTAGES of them and handles the narrow last slice.

## Test plan
- Exhaustive, WIDTH=6, STAGE_W=2, out_ready=1: all 4096 (x,y) back-to-back. Every s equals x+y, in order; e.g. 63+63 → 7'd126 appears 2 cycles after acceptance; 1 result/cycle.
- Back-pressure: out_ready=0, offer 5 ops. Exactly 3 accepted, then in_ready=0. out_ready pulsed once → 1 result out, 1 more accepted that cycle. No loss or duplication.
- Non-divisible width, WIDTH=7, STAGE_W=3: 127+1 → 8'd128; 127+127 → 8'd254; latency 2 cycles.
- Reset mid-flight: 3 ops in flight, rst asserted asynchronously between edges. out_valid=0 and s=0 immediately. in_ready=1 after release; no stale result ever appears.
- ADDER_PIPE_SUB_EN, WIDTH=6: 5−9 → 7'b1111100 (−4); 63−0 → 7'd63; 0−63 → 7'b1000001. Add and sub interleaved cycle by cycle stay correct.
- STAGE_W=WIDTH=6 (single stage): 1-cycle pipeline; 32+32 → 7'd64 visible right after the accepting edge; back-pressure rules still hold.
